// File: rtl/grf_wb_arbiter_pkg.sv
// grf_arb_pkg: shared constants and the write-back request type used by the
// GRF write-back arbiter, its result FIFO and its bus interface.
//   REG_ADDR_W / REG_DATA_W : register file address / data widths
//   REG_ZERO                : hard-wired zero register (writes are dropped)
//   wb_req_t                : one pending register write {a3, wd}
package grf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] a3;
        logic [REG_DATA_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if: bundles every handshake and bus signal of the GRF
// write-back arbiter.
//   pipe_valid/pipe_ready/pipe_a3/pipe_wd : pipeline write-back request
//   mdu_valid/mdu_ready/mdu_a3/mdu_wd     : multiply/divide result request
//   grf_we/grf_a3/grf_wd                  : register file write port
//   q_a1/q_a2 -> q_hit1/q_hit2            : pending-write hazard queries
// Handshake rule for both producers: a transfer happens on a rising clock
// edge where valid && ready are both high; a producer holding valid keeps
// a3/wd stable until that edge, and ready never depends on valid.
// Modports: master = producers/consumers around the arbiter, slave = arbiter.
interface grf_wb_arbiter_if;
    import grf_arb_pkg::*;

    logic                  pipe_valid;
    logic                  pipe_ready;
    logic [REG_ADDR_W-1:0] pipe_a3;
    logic [REG_DATA_W-1:0] pipe_wd;

    logic                  mdu_valid;
    logic                  mdu_ready;
    logic [REG_ADDR_W-1:0] mdu_a3;
    logic [REG_DATA_W-1:0] mdu_wd;

    logic                  grf_we;
    logic [REG_ADDR_W-1:0] grf_a3;
    logic [REG_DATA_W-1:0] grf_wd;

    logic [REG_ADDR_W-1:0] q_a1;
    logic [REG_ADDR_W-1:0] q_a2;
    logic                  q_hit1;
    logic                  q_hit2;

    modport master (
        output pipe_valid, pipe_a3, pipe_wd,
        output mdu_valid, mdu_a3, mdu_wd,
        output q_a1, q_a2,
        input  pipe_ready, mdu_ready,
        input  grf_we, grf_a3, grf_wd,
        input  q_hit1, q_hit2
    );

    modport slave (
        input  pipe_valid, pipe_a3, pipe_wd,
        input  mdu_valid, mdu_a3, mdu_wd,
        input  q_a1, q_a2,
        output pipe_ready, mdu_ready,
        output grf_we, grf_a3, grf_wd,
        output q_hit1, q_hit2
    );

endinterface

// File: rtl/grf_wb_arbiter_fifo.sv
// grf_wb_fifo: synchronous FIFO of wb_req_t buffering mdu results, with two
// combinational address-match ports over its valid entries.
//   clk, reset (sync, active-low)
//   push, push_data   : enqueue (ignored when full)
//   pop, head         : dequeue / current head entry (pop ignored when empty)
//   full, empty       : status from the current (pre-update) state
//   m_a1/m_a2 -> m_hit1/m_hit2 : some valid entry targets that register
module grf_wb_fifo
    import grf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_req_t               push_data,
    input  logic                  pop,
    output wb_req_t               head,
    output logic                  full,
    output logic                  empty,
    input  logic [REG_ADDR_W-1:0] m_a1,
    input  logic [REG_ADDR_W-1:0] m_a2,
    output logic                  m_hit1,
    output logic                  m_hit2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    always_comb begin
        m_hit1 = 1'b0;
        m_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(i) - rd_ptr} < count) begin
                if (mem[i].a3 == m_a1) m_hit1 = 1'b1;
                if (mem[i].a3 == m_a2) m_hit2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: arbitrates the GRF single write port between the pipeline
// write-back stage (fixed priority) and buffered mdu results, with a
// starvation counter that forces the FIFO head after STARVE_LIMIT losses.
//   clk, reset (sync, active-low)
//   bus   : grf_wb_arbiter_if.slave (pipe/mdu handshakes, GRF port, queries)
// Optional build macro GRF_ARB_STATS_EN adds 32-bit wrapping counters:
//   stat_pipe_wr (pipe grants), stat_mdu_wr (FIFO grants),
//   stat_forced (forced cycles).
module grf_wb_arbiter
    import grf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    grf_wb_arbiter_if.slave bus
`ifdef GRF_ARB_STATS_EN
    ,
    output logic [31:0] stat_pipe_wr,
    output logic [31:0] stat_mdu_wr,
    output logic [31:0] stat_forced
`endif
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t         head;
    wb_req_t         push_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            forced;
    logic            pipe_grant;
    logic            fifo_hit1;
    logic            fifo_hit2;
    logic [SC_W-1:0] starve_cnt;

    assign forced         = !fifo_empty && (starve_cnt == SC_W'(STARVE_LIMIT));
    assign bus.pipe_ready = !forced;
    // A pipe write to register 0 completes its handshake but leaves the
    // port free for the FIFO head.
    assign pipe_grant     = bus.pipe_valid && !forced && (bus.pipe_a3 != REG_ZERO);
    assign pop            = !fifo_empty && (forced || !pipe_grant);

    assign bus.mdu_ready  = !fifo_full;
    assign push           = bus.mdu_valid && !fifo_full && (bus.mdu_a3 != REG_ZERO);
    assign push_data      = '{a3: bus.mdu_a3, wd: bus.mdu_wd};

    grf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .m_a1      (bus.q_a1),
        .m_a2      (bus.q_a2),
        .m_hit1    (fifo_hit1),
        .m_hit2    (fifo_hit2)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
            bus.grf_we <= 1'b0;
            bus.grf_a3 <= '0;
            bus.grf_wd <= '0;
        end else begin
            // Non-empty and not popped means the head lost this cycle.
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            if (pop) begin
                bus.grf_we <= 1'b1;
                bus.grf_a3 <= head.a3;
                bus.grf_wd <= head.wd;
            end else if (pipe_grant) begin
                bus.grf_we <= 1'b1;
                bus.grf_a3 <= bus.pipe_a3;
                bus.grf_wd <= bus.pipe_wd;
            end else begin
                bus.grf_we <= 1'b0;
            end
        end
    end

    // The output stage counts as pending until the GRF commits it.
    assign bus.q_hit1 = (bus.q_a1 != REG_ZERO) &&
                        (fifo_hit1 || (bus.grf_we && (bus.grf_a3 == bus.q_a1)));
    assign bus.q_hit2 = (bus.q_a2 != REG_ZERO) &&
                        (fifo_hit2 || (bus.grf_we && (bus.grf_a3 == bus.q_a2)));

`ifdef GRF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_pipe_wr <= '0;
            stat_mdu_wr  <= '0;
            stat_forced  <= '0;
        end else begin
            if (pipe_grant) stat_pipe_wr <= stat_pipe_wr + 32'd1;
            if (pop)        stat_mdu_wr  <= stat_mdu_wr + 32'd1;
            if (forced)     stat_forced  <= stat_forced + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed bench for grf_wb_arbiter. A queue-based model
// of the buffered mdu results and the output stage is checked against the
// DUT on every falling edge; directed sequences add literal expectations.
module tb_grf_wb_arbiter;
    import grf_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk;
    logic reset;

    grf_wb_arbiter_if wb_if ();

`ifdef GRF_ARB_STATS_EN
    logic [31:0] stat_pipe_wr;
    logic [31:0] stat_mdu_wr;
    logic [31:0] stat_forced;
`endif

    grf_wb_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wb_if)
`ifdef GRF_ARB_STATS_EN
        ,
        .stat_pipe_wr (stat_pipe_wr),
        .stat_mdu_wr  (stat_mdu_wr),
        .stat_forced  (stat_forced)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    // exp_q holds the buffered mdu writes {a3, wd} in arrival order.
    logic [36:0]     exp_q[$];
    logic            m_we    = 1'b0;
    logic [4:0]      m_a3    = 5'd0;
    logic [31:0]     m_wd    = 32'd0;
    int              m_lost  = 0;   // consecutive cycles the head has lost

    function automatic logic pending(input logic [4:0] a);
        logic hit;
        hit = 1'b0;
        if (a != 5'd0) begin
            foreach (exp_q[i]) if (exp_q[i][36:32] == a) hit = 1'b1;
            if (m_we && m_a3 == a) hit = 1'b1;
        end
        return hit;
    endfunction

    // Outputs are compared, then the model advances to the state the next
    // rising edge will produce from the inputs currently applied.
    always @(negedge clk) begin
        logic        busy;
        logic        force_head;
        logic        pipe_writes;
        logic        mdu_takes;
        logic [36:0] h;
        busy       = (exp_q.size() > 0);
        force_head = busy && (m_lost == LIMIT);

        check("pipe_ready", 32'(wb_if.pipe_ready), 32'(!force_head));
        check("mdu_ready",  32'(wb_if.mdu_ready),  32'(exp_q.size() < DEPTH));
        check("grf_we",     32'(wb_if.grf_we),     32'(m_we));
        check("grf_a3",     32'(wb_if.grf_a3),     32'(m_a3));
        check("grf_wd",     wb_if.grf_wd,          m_wd);
        check("q_hit1",     32'(wb_if.q_hit1),     32'(pending(wb_if.q_a1)));
        check("q_hit2",     32'(wb_if.q_hit2),     32'(pending(wb_if.q_a2)));

        if (!reset) begin
            exp_q.delete();
            m_we   = 1'b0;
            m_a3   = 5'd0;
            m_wd   = 32'd0;
            m_lost = 0;
        end else begin
            pipe_writes = wb_if.pipe_valid && !force_head && (wb_if.pipe_a3 != 5'd0);
            mdu_takes   = wb_if.mdu_valid && (exp_q.size() < DEPTH) && (wb_if.mdu_a3 != 5'd0);
            if (busy && (force_head || !pipe_writes)) begin
                h      = exp_q.pop_front();
                m_we   = 1'b1;
                m_a3   = h[36:32];
                m_wd   = h[31:0];
                m_lost = 0;
            end else if (pipe_writes) begin
                m_we   = 1'b1;
                m_a3   = wb_if.pipe_a3;
                m_wd   = wb_if.pipe_wd;
                m_lost = busy ? ((m_lost < LIMIT) ? m_lost + 1 : LIMIT) : 0;
            end else begin
                m_we   = 1'b0;
                m_lost = 0;
            end
            if (mdu_takes) exp_q.push_back({wb_if.mdu_a3, wb_if.mdu_wd});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        wb_if.pipe_valid = 1'b0;
        wb_if.pipe_a3    = 5'd0;
        wb_if.pipe_wd    = 32'd0;
        wb_if.mdu_valid  = 1'b0;
        wb_if.mdu_a3     = 5'd0;
        wb_if.mdu_wd     = 32'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] a3, input logic [31:0] wd);
        wb_if.pipe_valid = 1'b1;
        wb_if.pipe_a3    = a3;
        wb_if.pipe_wd    = wd;
    endtask

    task automatic drive_mdu(input logic [4:0] a3, input logic [31:0] wd);
        wb_if.mdu_valid = 1'b1;
        wb_if.mdu_a3    = a3;
        wb_if.mdu_wd    = wd;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int   k;
        int   mi;
        logic p_acc;
        logic m_acc;

        reset = 1'b0;
        drive_idle();
        wb_if.q_a1 = 5'd0;
        wb_if.q_a2 = 5'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_grf_we", 32'(wb_if.grf_we), 32'd0);
        check("rst_grf_a3", 32'(wb_if.grf_a3), 32'd0);
        check("rst_mdu_ready", 32'(wb_if.mdu_ready), 32'd1);
        check("rst_pipe_ready", 32'(wb_if.pipe_ready), 32'd1);
        tick();

        // Pipe only
        drive_pipe(5'd5, 32'h1234);
        #1;
        check("pipe_only_ready", 32'(wb_if.pipe_ready), 32'd1);
        tick();
        drive_idle();
        #1;
        check("pipe_only_we", 32'(wb_if.grf_we), 32'd1);
        check("pipe_only_a3", 32'(wb_if.grf_a3), 32'd5);
        check("pipe_only_wd", wb_if.grf_wd, 32'h1234);
        tick();
        check("pipe_only_we_drop", 32'(wb_if.grf_we), 32'd0);

        // Mdu only, with hazard query on r7
        wb_if.q_a1 = 5'd7;
        drive_mdu(5'd7, 32'hCAFE);
        #1;
        check("mdu_only_hit_c0", 32'(wb_if.q_hit1), 32'd0);
        tick();
        drive_idle();
        #1;
        check("mdu_only_hit_c1", 32'(wb_if.q_hit1), 32'd1);
        check("mdu_only_we_c1", 32'(wb_if.grf_we), 32'd0);
        tick();
        check("mdu_only_we_c2", 32'(wb_if.grf_we), 32'd1);
        check("mdu_only_a3_c2", 32'(wb_if.grf_a3), 32'd7);
        check("mdu_only_wd_c2", wb_if.grf_wd, 32'hCAFE);
        check("mdu_only_hit_c2", 32'(wb_if.q_hit1), 32'd1);
        tick();
        check("mdu_only_hit_c3", 32'(wb_if.q_hit1), 32'd0);

        // Starvation: continuous pipe, one mdu entry in cycle 0
        k = 0;
        for (int c = 0; c < 8; c++) begin
            drive_pipe(5'(10 + k), 32'h100 + 32'(k));
            if (c == 0) drive_mdu(5'd3, 32'hBEEF);
            else wb_if.mdu_valid = 1'b0;
            #1;
            check("starve_pipe_ready", 32'(wb_if.pipe_ready), (c == 5) ? 32'd0 : 32'd1);
            p_acc = wb_if.pipe_ready;
            tick();
            if (p_acc) k++;
            if (c == 5) begin
                check("starve_forced_a3", 32'(wb_if.grf_a3), 32'd3);
                check("starve_forced_wd", wb_if.grf_wd, 32'hBEEF);
            end
            if (c == 6) check("starve_resume_a3", 32'(wb_if.grf_a3), 32'd15);
        end
        drive_idle();
        tick();

        // Full FIFO with the pipe saturating the port
        k  = 0;
        mi = 0;
        for (int c = 0; c < 7; c++) begin
            drive_pipe(5'd12, 32'h200 + 32'(k));
            if (mi < 3) drive_mdu(5'(20 + mi), 32'hA0 + 32'(mi));
            else wb_if.mdu_valid = 1'b0;
            #1;
            if (c == 2) check("full_ready_c2", 32'(wb_if.mdu_ready), 32'd0);
            if (c == 5) begin
                check("full_ready_c5", 32'(wb_if.mdu_ready), 32'd0);
                check("full_forced_c5", 32'(wb_if.pipe_ready), 32'd0);
            end
            if (c == 6) check("full_ready_c6", 32'(wb_if.mdu_ready), 32'd1);
            p_acc = wb_if.pipe_ready;
            m_acc = wb_if.mdu_valid && wb_if.mdu_ready;
            tick();
            if (p_acc) k++;
            if (m_acc) mi++;
        end
        check("full_third_taken", 32'(mi), 32'd3);
        drive_idle();
        tick();
        check("full_drain_a3_1", 32'(wb_if.grf_a3), 32'd21);
        tick();
        check("full_drain_a3_2", 32'(wb_if.grf_a3), 32'd22);
        tick();
        check("full_drain_idle", 32'(wb_if.grf_we), 32'd0);

        // Register 0 writes
        drive_mdu(5'd9, 32'h99);
        tick();
        drive_pipe(5'd0, 32'hDEAD);
        drive_mdu(5'd0, 32'hF00D);
        #1;
        check("r0_pipe_ready", 32'(wb_if.pipe_ready), 32'd1);
        check("r0_mdu_ready", 32'(wb_if.mdu_ready), 32'd1);
        tick();
        drive_idle();
        #1;
        check("r0_mdu_granted_a3", 32'(wb_if.grf_a3), 32'd9);
        check("r0_mdu_granted_we", 32'(wb_if.grf_we), 32'd1);
        tick();
        check("r0_nothing_queued", 32'(wb_if.grf_we), 32'd0);

        // Reset mid-operation with two entries queued
        wb_if.q_a1 = 5'd25;
        wb_if.q_a2 = 5'd26;
        drive_pipe(5'd14, 32'h300);
        drive_mdu(5'd25, 32'h25);
        tick();
        drive_pipe(5'd15, 32'h301);
        drive_mdu(5'd26, 32'h26);
        tick();
        drive_pipe(5'd16, 32'h302);
        wb_if.mdu_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rstmid_full", 32'(wb_if.mdu_ready), 32'd0);
        check("rstmid_hit_before", 32'(wb_if.q_hit2), 32'd1);
        tick();
        reset = 1'b1;
        drive_idle();
        #1;
        check("rstmid_we", 32'(wb_if.grf_we), 32'd0);
        check("rstmid_mdu_ready", 32'(wb_if.mdu_ready), 32'd1);
        check("rstmid_hit1", 32'(wb_if.q_hit1), 32'd0);
        check("rstmid_hit2", 32'(wb_if.q_hit2), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rstmid_no_write", 32'(wb_if.grf_we), 32'd0);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
